// File: rtl/lock_reg_write_arbiter_if.sv
// Requester-side write bus for lock_reg_write_arbiter.
// Handshake: a requester raises req[i] with addr/data/lock stable and holds it until ack[i]; err[i] qualifies ack[i].
interface lock_reg_write_arbiter_if #(
   parameter int NREQ = 2,
   parameter int AW   = 3,
   parameter int DW   = 16
);
   logic [NREQ-1:0]    req;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_lock;
   logic [NREQ-1:0]    ack;
   logic [NREQ-1:0]    err;

   modport master (output req, req_addr, req_data, req_lock, input ack, err);
   modport slave  (input req, req_addr, req_data, req_lock, output ack, err);
endinterface

// File: rtl/lock_reg_write_arbiter.sv
// Round-robin write arbiter in front of a bank of sticky-lockable config registers.
// A locked register accepts writes only while debug_mode and trusted are both high.
module lock_reg_write_arbiter #(
   parameter int NREQ  = 2,
   parameter int NREGS = 4,
   parameter int AW    = 3,
   parameter int DW    = 16
) (
   input  logic                     Clk,
   input  logic                     resetn,
   lock_reg_write_arbiter_if.slave  bus,
   input  logic                     debug_mode,
   input  logic                     trusted,
   output logic                     busy,
   output logic [NREGS-1:0]         lock_status,
   output logic [NREGS*DW-1:0]      reg_data,
   output logic [1:0]               fsm_state
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   win_id;
   logic [PW-1:0]   pick_id;
   logic [PW:0]     cand;
   logic            pick_found;
   logic [AW-1:0]   lat_addr;
   logic [DW-1:0]   lat_data;
   logic            lat_lock;
   logic            rejected;
   logic            addr_ok;
   logic            cur_locked;
   logic            write_ok;
   logic [NREQ-1:0] ack_c;
   logic [NREQ-1:0] err_c;

   assign bus.ack   = ack_c;
   assign bus.err   = err_c;
   assign fsm_state = state;

   // First requesting index at or after rr_ptr, wrapping modulo NREQ.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      cand       = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, rr_ptr} + (PW+1)'(k);
         if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
         if (!pick_found && bus.req[cand[PW-1:0]]) begin
            pick_found = 1'b1;
            pick_id    = cand[PW-1:0];
         end
      end
   end

   always_comb begin
      addr_ok    = (32'(lat_addr) < 32'(NREGS));
      cur_locked = 1'b0;
      for (int j = 0; j < NREGS; j++) begin
         if (32'(lat_addr) == 32'(j)) cur_locked = lock_status[j];
      end
      write_ok = addr_ok & (~cur_locked | (debug_mode & trusted));
   end

   always_ff @(posedge Clk) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ack_c     = '0;
      err_c     = '0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (|bus.req) state_nxt = GRANT;
         end
         GRANT: begin
            busy      = 1'b1;
            state_nxt = RESP;
         end
         RESP: begin
            busy          = 1'b1;
            ack_c[win_id] = 1'b1;
            err_c[win_id] = rejected;
            state_nxt     = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Only the copy latched at grant is used; the bus fields may change afterwards.
   always_ff @(posedge Clk) begin
      if (!resetn) begin
         rr_ptr      <= '0;
         win_id      <= '0;
         lat_addr    <= '0;
         lat_data    <= '0;
         lat_lock    <= 1'b0;
         rejected    <= 1'b0;
         lock_status <= '0;
         reg_data    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  win_id   <= pick_id;
                  lat_addr <= bus.req_addr[int'(pick_id)*AW +: AW];
                  lat_data <= bus.req_data[int'(pick_id)*DW +: DW];
                  lat_lock <= bus.req_lock[pick_id];
               end
            end
            GRANT: begin
               rejected <= ~write_ok;
               for (int j = 0; j < NREGS; j++) begin
                  if (write_ok && (32'(lat_addr) == 32'(j))) begin
                     reg_data[j*DW +: DW] <= lat_data;
                     if (lat_lock) lock_status[j] <= 1'b1;
                  end
               end
            end
            RESP: begin
               if (int'(win_id) == NREQ - 1) rr_ptr <= '0;
               else                          rr_ptr <= win_id + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_lock_reg_write_arbiter.sv
// Self-checking bench for lock_reg_write_arbiter: directed scenarios plus random
// single-requester writes, checked against an array-based register/lock model.
module tb_lock_reg_write_arbiter;
   localparam int NREQ  = 2;
   localparam int NREGS = 4;
   localparam int AW    = 3;
   localparam int DW    = 16;

   logic                clk = 1'b0;
   logic                resetn = 1'b0;
   logic                debug_mode = 1'b0;
   logic                trusted = 1'b0;
   logic                busy;
   logic [NREGS-1:0]    lock_status;
   logic [NREGS*DW-1:0] reg_data;
   logic [1:0]          fsm_state;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0]   exp_regs[NREGS];
   logic            exp_lock[NREGS];
   int              exp_rr;
   logic [NREQ-1:0] exp_q[$];

   lock_reg_write_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus();

   lock_reg_write_arbiter #(.NREQ(NREQ), .NREGS(NREGS), .AW(AW), .DW(DW)) dut (
      .Clk         (clk),
      .resetn      (resetn),
      .bus         (bus),
      .debug_mode  (debug_mode),
      .trusted     (trusted),
      .busy        (busy),
      .lock_status (lock_status),
      .reg_data    (reg_data),
      .fsm_state   (fsm_state)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic void model_reset();
      for (int j = 0; j < NREGS; j++) begin
         exp_regs[j] = '0;
         exp_lock[j] = 1'b0;
      end
      exp_rr = 0;
   endfunction

   function automatic int model_pick(input logic [NREQ-1:0] mask);
      for (int k = 0; k < NREQ; k++) begin
         if (mask[(exp_rr + k) % NREQ]) return (exp_rr + k) % NREQ;
      end
      return -1;
   endfunction

   // Applies one served write; returns 1 when the write must be rejected.
   function automatic logic model_write(input int id, input int addr, input logic [DW-1:0] data,
                                        input logic lk, input logic dbg, input logic tr);
      logic ok;
      ok = (addr < NREGS) && (!exp_lock[addr] || (dbg && tr));
      if (ok) begin
         exp_regs[addr] = data;
         if (lk) exp_lock[addr] = 1'b1;
      end
      exp_rr = (id + 1) % NREQ;
      return !ok;
   endfunction

   function automatic logic [NREGS*DW-1:0] exp_reg_data();
      logic [NREGS*DW-1:0] v;
      for (int j = 0; j < NREGS; j++) v[j*DW +: DW] = exp_regs[j];
      return v;
   endfunction

   function automatic logic [NREGS-1:0] exp_lock_vec();
      logic [NREGS-1:0] v;
      for (int j = 0; j < NREGS; j++) v[j] = exp_lock[j];
      return v;
   endfunction

   // ---------------- drivers ----------------
   task automatic apply_reset();
      @(negedge clk);
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      model_reset();
   endtask

   task automatic do_write(input int id, input int addr, input logic [DW-1:0] data,
                           input logic lk, input logic dbg, input logic tr);
      logic            e_err;
      logic [NREQ-1:0] e_ack;
      int              waited;
      @(negedge clk);
      debug_mode                 = dbg;
      trusted                    = tr;
      bus.req_addr[id*AW +: AW]  = AW'(addr);
      bus.req_data[id*DW +: DW]  = data;
      bus.req_lock[id]           = lk;
      bus.req[id]                = 1'b1;
      e_err = model_write(id, addr, data, lk, dbg, tr);
      e_ack = '0;
      e_ack[id] = 1'b1;
      waited = 0;
      while (bus.ack === '0 && waited < 6) begin
         @(negedge clk);
         waited++;
      end
      n_checks++;
      if (waited != 2 || bus.ack !== e_ack) begin
         n_fail++;
         $display("FAIL write_ack: got ack=%b after %0d cycles, expected ack=%b after 2", bus.ack, waited, e_ack);
      end
      n_checks++;
      if (bus.err !== (e_err ? e_ack : '0)) begin
         n_fail++;
         $display("FAIL write_err: got err=%b, expected %b (addr=%0d)", bus.err, e_err ? e_ack : '0, addr);
      end
      n_checks++;
      if (reg_data !== exp_reg_data()) begin
         n_fail++;
         $display("FAIL write_reg_data: got %h, expected %h", reg_data, exp_reg_data());
      end
      n_checks++;
      if (lock_status !== exp_lock_vec()) begin
         n_fail++;
         $display("FAIL write_lock_status: got %b, expected %b", lock_status, exp_lock_vec());
      end
      bus.req[id]      = 1'b0;
      bus.req_lock[id] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || bus.ack !== '0 || bus.err !== '0) begin
         n_fail++;
         $display("FAIL write_idle: got busy=%b ack=%b err=%b, expected all 0", busy, bus.ack, bus.err);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk);
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (reg_data !== '0 || lock_status !== '0) begin
         n_fail++;
         $display("FAIL reset_regs: got reg_data=%h lock=%b, expected 0", reg_data, lock_status);
      end
      n_checks++;
      if (busy !== 1'b0 || bus.ack !== '0 || bus.err !== '0 || fsm_state !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got busy=%b ack=%b err=%b state=%0d, expected 0", busy, bus.ack, bus.err, fsm_state);
      end
      resetn = 1'b1;
      model_reset();
   endtask

   task automatic test_basic_write();
      do_write(0, 1, 16'hA5A5, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (reg_data[1*DW +: DW] !== 16'hA5A5) begin
         n_fail++;
         $display("FAIL basic_reg1: got %h, expected a5a5", reg_data[1*DW +: DW]);
      end
   endtask

   task automatic test_lock_reject();
      do_write(0, 2, 16'h1234, 1'b1, 1'b0, 1'b0);
      do_write(1, 2, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (reg_data[2*DW +: DW] !== 16'h1234 || lock_status !== 4'b0100) begin
         n_fail++;
         $display("FAIL lock_reject: got reg2=%h lock=%b, expected 1234 0100", reg_data[2*DW +: DW], lock_status);
      end
   endtask

   task automatic test_debug_override();
      do_write(1, 2, 16'hBEEF, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (reg_data[2*DW +: DW] !== 16'h1234) begin
         n_fail++;
         $display("FAIL debug_untrusted: got reg2=%h, expected 1234", reg_data[2*DW +: DW]);
      end
      do_write(0, 2, 16'hBEEF, 1'b1, 1'b1, 1'b1);
      n_checks++;
      if (reg_data[2*DW +: DW] !== 16'hBEEF || lock_status[2] !== 1'b1) begin
         n_fail++;
         $display("FAIL debug_trusted: got reg2=%h lock2=%b, expected beef 1", reg_data[2*DW +: DW], lock_status[2]);
      end
      do_write(1, 3, 16'h0F0F, 1'b0, 1'b0, 1'b1);
      debug_mode = 1'b0;
      trusted    = 1'b0;
   endtask

   task automatic test_illegal_addr();
      do_write(0, 5, 16'h0001, 1'b0, 1'b0, 1'b0);
      do_write(1, 7, 16'h00FF, 1'b1, 1'b1, 1'b1);
      debug_mode = 1'b0;
      trusted    = 1'b0;
   endtask

   task automatic test_round_robin();
      logic [NREQ-1:0] got;
      logic [NREQ-1:0] e_ack;
      int              w;
      int              waited;
      int              rr_save;
      apply_reset();
      rr_save = exp_rr;
      for (int i = 0; i < 4; i++) begin
         w = model_pick(2'b11);
         e_ack = '0;
         e_ack[w] = 1'b1;
         exp_q.push_back(e_ack);
         exp_rr = (w + 1) % NREQ;
      end
      exp_rr = rr_save;
      @(negedge clk);
      bus.req_addr = {AW'(3), AW'(0)};
      bus.req_data = {16'h2222, 16'h1111};
      bus.req_lock = '0;
      bus.req      = 2'b11;
      for (int i = 0; i < 4; i++) begin
         waited = 0;
         while (bus.ack === '0 && waited < 6) begin
            @(negedge clk);
            waited++;
         end
         got   = bus.ack;
         e_ack = exp_q.pop_front();
         n_checks++;
         if (got !== e_ack || bus.err !== '0) begin
            n_fail++;
            $display("FAIL rr_order[%0d]: got ack=%b err=%b, expected ack=%b err=00", i, got, bus.err, e_ack);
         end
         w = (e_ack[1]) ? 1 : 0;
         void'(model_write(w, (w == 1) ? 3 : 0, (w == 1) ? 16'h2222 : 16'h1111, 1'b0, 1'b0, 1'b0));
         n_checks++;
         if (reg_data !== exp_reg_data()) begin
            n_fail++;
            $display("FAIL rr_reg_data[%0d]: got %h, expected %h", i, reg_data, exp_reg_data());
         end
         if (i == 3) bus.req = '0;
         @(negedge clk);
         n_checks++;
         if (busy !== 1'b0 || bus.ack !== '0) begin
            n_fail++;
            $display("FAIL rr_idle_gap[%0d]: got busy=%b ack=%b, expected 0 00", i, busy, bus.ack);
         end
         if (i < 3) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b1 || bus.ack !== '0) begin
               n_fail++;
               $display("FAIL rr_grant_busy[%0d]: got busy=%b ack=%b, expected 1 00", i, busy, bus.ack);
            end
         end
      end
   endtask

   task automatic test_reset_in_grant();
      int waited;
      do_write(1, 1, 16'h7777, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      bus.req_addr[0 +: AW] = '0;
      bus.req_data[0 +: DW] = 16'h5A5A;
      bus.req_lock[0]       = 1'b0;
      bus.req[0]            = 1'b1;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_grant_busy: got busy=%b, expected 1", busy);
      end
      resetn = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.ack !== '0 || reg_data !== '0 || lock_status !== '0 || fsm_state !== 2'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_grant_clear: got ack=%b reg_data=%h lock=%b state=%0d busy=%b, expected all 0",
                  bus.ack, reg_data, lock_status, fsm_state, busy);
      end
      model_reset();
      resetn = 1'b1;
      waited = 0;
      while (bus.ack === '0 && waited < 6) begin
         @(negedge clk);
         waited++;
      end
      void'(model_write(0, 0, 16'h5A5A, 1'b0, 1'b0, 1'b0));
      n_checks++;
      if (bus.ack !== 2'b01 || bus.err !== '0 || waited != 2 || reg_data !== exp_reg_data()) begin
         n_fail++;
         $display("FAIL rst_grant_reserve: got ack=%b err=%b after %0d cycles reg_data=%h, expected 01 00 after 2 %h",
                  bus.ack, bus.err, waited, reg_data, exp_reg_data());
      end
      bus.req[0] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_random();
      for (int t = 0; t < 60; t++) begin
         if (t % 20 == 0) apply_reset();
         do_write($urandom_range(0, NREQ - 1), $urandom_range(0, 5), DW'($urandom),
                  ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      debug_mode = 1'b0;
      trusted    = 1'b0;
   endtask

   initial begin
      bus.req      = '0;
      bus.req_addr = '0;
      bus.req_data = '0;
      bus.req_lock = '0;
      model_reset();
      test_reset();
      test_basic_write();
      test_lock_reject();
      test_debug_override();
      test_illegal_addr();
      test_round_robin();
      test_reset_in_grant();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
